dac_sweep_gen: RTL and testbench
================================

DAC_SWEEP_GEN -- requirements
Module: dac_sweep_gen

Interface
REQ-001 Parameter ADDR_BASE, default 16'h0100, base address of the six-word register block (offsets +0..+5).
REQ-002 clk_in  input  1  sole clock, all logic rising-edge.
REQ-003 rst_in  input  1  reset, asynchronous, active-high.
REQ-004 cmd_trig_in  input  1  one-cycle write strobe.
REQ-005 cmd_addr_in  input  16  register address for write and readback.
REQ-006 cmd_data_in  input  16  write data.
REQ-007 cmd_data_out  output  16  registered readback of register at cmd_addr_in; 0 if unmapped.
REQ-008 DAC0_out  output  16  sweep sample, unsigned, feeds DAC channel 0 input of the DAC driver.
REQ-009 DAC1_out  output  16  registered OFFSET value, feeds DAC channel 1 input.
REQ-010 sync_out  output  1  one-cycle pulse at each sweep turn-around/wrap.
REQ-011 dir_out  output  1  1 = UP state, 0 = DOWN or IDLE.

Function
REQ-012 Register map (offset: name, reset): +0 CTRL (bit0 EN, bit1 MODE 0=triangle 1=sawtooth, bit2 RESTART self-clearing, reads 0), 0; +1 MIN, 0; +2 MAX, 16'hFFFF; +3 STEP, 1; +4 DIV, 0; +5 OFFSET, 16'h8000.
REQ-013 Write occurs on the clock where cmd_trig_in=1 and cmd_addr_in is mapped; unmapped writes ignored.
REQ-014 cmd_data_out shall equal the register addressed on the previous cycle (1-cycle latency).
REQ-015 Prescaler counts 0..DIV; tick asserted on the cycle the count equals DIV, then count returns to 0; one sweep update per DIV+1 cycles.
REQ-016 States IDLE, UP, DOWN; IDLE when EN=0 or MIN>=MAX; DAC0_out = MIN in IDLE, prescaler held at 0.
REQ-017 IDLE -> UP on the cycle after EN=1 with MIN<MAX; DAC0_out starts at MIN.
REQ-018 UP at tick: if DAC0_out+STEP (17-bit sum) >= MAX, DAC0_out = MAX, sync_out=1, triangle -> DOWN, sawtooth -> DAC0_out = MIN on the following tick and stay UP; else DAC0_out += STEP.
REQ-019 DOWN at tick: if DAC0_out < MIN+STEP (17-bit), DAC0_out = MIN, sync_out=1, -> UP; else DAC0_out -= STEP.
REQ-020 Arithmetic unsigned, no wrap-around; DAC0_out never outside [MIN,MAX] after the first tick following any config change.
REQ-021 STEP=0: DAC0_out holds, no sync_out pulses, state unchanged.
REQ-022 Config writes during a sweep take effect from the next tick; a tick coinciding with a write uses the old values.
REQ-023 RESTART write: next cycle DAC0_out = MIN, prescaler = 0, state UP (if EN=1 and MIN<MAX); EN=0 in the same write wins (IDLE).
REQ-024 EN cleared mid-sweep: next cycle IDLE, DAC0_out = MIN, sync_out=0.
REQ-025 DAC1_out = OFFSET, updated 1 cycle after its write.

Reset
REQ-026 rst_in=1 shall immediately force registers to REQ-012 values, state IDLE, prescaler 0, DAC0_out=0, DAC1_out=16'h8000, sync_out=0, dir_out=0, cmd_data_out=0.
REQ-027 After rst_in deasserts, no sweep activity until EN is written 1.

Verification
REQ-028 Reset: assert rst_in mid-sweep -> outputs at REQ-026 values without waiting for a clock edge; readback of +2 gives 16'hFFFF.
REQ-029 MIN=100, MAX=110, STEP=4, DIV=0, triangle, EN=1 -> DAC0_out 100,104,108,110,106,102,100,104,...; sync_out pulses at 110 and at 100.
REQ-030 Same config, sawtooth -> 100,104,108,110,100,104,...; sync_out pulses at 110 only; dir_out stays 1.
REQ-031 DIV=2, STEP=1, MIN=0, MAX=10 -> DAC0_out changes exactly every 3 cycles.
REQ-032 MIN=16'hFFF0, MAX=16'hFFFF, STEP=16'h0010, triangle -> 16'hFFF0, 16'hFFFF, 16'hFFF0; no overflow to 0.
REQ-033 EN=0 written mid-sweep at DAC0_out=108 -> next cycle DAC0_out=100, dir_out=0; MIN=MAX=50 with EN=1 -> stays IDLE, DAC0_out=50.

Source files
------------

// File: rtl/dac_sweep_gen.sv
// rtl/dac_sweep_gen.sv - register-programmed triangle/sawtooth DAC sweep generator
module dac_sweep_gen #(
   parameter logic [15:0] ADDR_BASE = 16'h0100
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        cmd_trig_in,
   input  logic [15:0] cmd_addr_in,
   input  logic [15:0] cmd_data_in,
   output logic [15:0] cmd_data_out,
   output logic [15:0] DAC0_out,
   output logic [15:0] DAC1_out,
   output logic        sync_out,
   output logic        dir_out
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_UP   = 2'd1,
      ST_DOWN = 2'd2
   } state_t;

   logic        en_q, en_d;
   logic        mode_q, mode_d;
   logic [15:0] min_q, min_d;
   logic [15:0] max_q, max_d;
   logic [15:0] step_q, step_d;
   logic [15:0] div_q, div_d;
   logic [15:0] offset_q, offset_d;
   logic [15:0] rdata_q, rdata_d;

   state_t      state_q, state_d;
   logic [15:0] dac_q, dac_d;
   logic [15:0] cnt_q, cnt_d;
   logic        sync_q, sync_d;
   logic        dir_q, dir_d;

   logic [15:0] reg_off;
   logic        reg_hit;
   logic        wr_hit;
   logic        wr_ctrl;
   logic        restart;
   logic        en_eff;
   logic        run_ok;
   logic        tick;
   logic [16:0] up_sum;
   logic [16:0] down_floor;
   logic [15:0] down_diff;

   assign reg_off    = cmd_addr_in - ADDR_BASE;
   assign reg_hit    = (reg_off < 16'd6);
   assign wr_hit     = cmd_trig_in & reg_hit;
   assign wr_ctrl    = wr_hit & (reg_off == 16'd0);
   assign restart    = wr_ctrl & cmd_data_in[2];
   // A CTRL write acts on the very edge it is presented, so EN/RESTART show up next cycle
   assign en_eff     = wr_ctrl ? cmd_data_in[0] : en_q;
   assign run_ok     = en_eff & (min_q < max_q);
   assign tick       = (cnt_q == div_q);
   assign up_sum     = {1'b0, dac_q} + {1'b0, step_q};
   assign down_floor = {1'b0, min_q} + {1'b0, step_q};
   assign down_diff  = dac_q - step_q;

   // Register file write decode; RESTART is a strobe and is never stored
   always_comb begin
      en_d     = en_q;
      mode_d   = mode_q;
      min_d    = min_q;
      max_d    = max_q;
      step_d   = step_q;
      div_d    = div_q;
      offset_d = offset_q;
      if (wr_hit) begin
         case (reg_off[2:0])
            3'd0: begin
               en_d   = cmd_data_in[0];
               mode_d = cmd_data_in[1];
            end
            3'd1:    min_d    = cmd_data_in;
            3'd2:    max_d    = cmd_data_in;
            3'd3:    step_d   = cmd_data_in;
            3'd4:    div_d    = cmd_data_in;
            3'd5:    offset_d = cmd_data_in;
            default: ;
         endcase
      end
   end

   // Readback mux, registered for one cycle of latency
   always_comb begin
      rdata_d = 16'd0;
      if (reg_hit) begin
         case (reg_off[2:0])
            3'd0:    rdata_d = {14'd0, mode_q, en_q};
            3'd1:    rdata_d = min_q;
            3'd2:    rdata_d = max_q;
            3'd3:    rdata_d = step_q;
            3'd4:    rdata_d = div_q;
            3'd5:    rdata_d = offset_q;
            default: rdata_d = 16'd0;
         endcase
      end
   end

   // Sweep state machine: prescaler tick advances the sample, clamped into [MIN,MAX]
   always_comb begin
      state_d = state_q;
      dac_d   = dac_q;
      cnt_d   = cnt_q;
      sync_d  = 1'b0;
      if (!run_ok) begin
         state_d = ST_IDLE;
         dac_d   = min_q;
         cnt_d   = 16'd0;
      end else if (state_q == ST_IDLE || restart) begin
         state_d = ST_UP;
         dac_d   = min_q;
         cnt_d   = 16'd0;
      end else begin
         cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
         if (tick && step_q != 16'd0) begin
            case (state_q)
               ST_UP: begin
                  if (mode_q && dac_q >= max_q) begin
                     dac_d = min_q;
                  end else if (up_sum >= {1'b0, max_q}) begin
                     dac_d  = max_q;
                     sync_d = 1'b1;
                     if (!mode_q) state_d = ST_DOWN;
                  end else if (up_sum[15:0] < min_q) begin
                     dac_d = min_q;
                  end else begin
                     dac_d = up_sum[15:0];
                  end
               end
               ST_DOWN: begin
                  if ({1'b0, dac_q} < down_floor) begin
                     dac_d   = min_q;
                     sync_d  = 1'b1;
                     state_d = ST_UP;
                  end else if (down_diff > max_q) begin
                     dac_d = max_q;
                  end else begin
                     dac_d = down_diff;
                  end
               end
               default: state_d = ST_IDLE;
            endcase
         end
      end
      dir_d = (state_d == ST_UP);
   end

   // All state, with asynchronous reset to the power-on register values
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         en_q     <= 1'b0;
         mode_q   <= 1'b0;
         min_q    <= 16'd0;
         max_q    <= 16'hFFFF;
         step_q   <= 16'd1;
         div_q    <= 16'd0;
         offset_q <= 16'h8000;
         rdata_q  <= 16'd0;
         state_q  <= ST_IDLE;
         dac_q    <= 16'd0;
         cnt_q    <= 16'd0;
         sync_q   <= 1'b0;
         dir_q    <= 1'b0;
      end else begin
         en_q     <= en_d;
         mode_q   <= mode_d;
         min_q    <= min_d;
         max_q    <= max_d;
         step_q   <= step_d;
         div_q    <= div_d;
         offset_q <= offset_d;
         rdata_q  <= rdata_d;
         state_q  <= state_d;
         dac_q    <= dac_d;
         cnt_q    <= cnt_d;
         sync_q   <= sync_d;
         dir_q    <= dir_d;
      end
   end

   assign cmd_data_out = rdata_q;
   assign DAC0_out     = dac_q;
   assign DAC1_out     = offset_q;
   assign sync_out     = sync_q;
   assign dir_out      = dir_q;

endmodule

// File: tb/tb_dac_sweep_gen.sv
// tb/tb_dac_sweep_gen.sv - directed self-checking bench for dac_sweep_gen
module tb_dac_sweep_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        trig;
   logic [15:0] addr;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic [15:0] dac0;
   logic [15:0] dac1;
   logic        sync;
   logic        dir;

   int checks   = 0;
   int failures = 0;

   logic [15:0] tri_seq  [8];
   logic        tri_sync [8];
   logic        tri_dir  [8];
   logic [15:0] saw_seq  [8];
   logic        saw_sync [8];
   logic [15:0] big_seq  [4];
   logic        big_sync [4];

   dac_sweep_gen #(.ADDR_BASE(16'h0100)) dut (
      .clk_in       (clk),
      .rst_in       (rst),
      .cmd_trig_in  (trig),
      .cmd_addr_in  (addr),
      .cmd_data_in  (wdata),
      .cmd_data_out (rdata),
      .DAC0_out     (dac0),
      .DAC1_out     (dac1),
      .sync_out     (sync),
      .dir_out      (dir)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Called at a negedge; the write lands on the next posedge, returns at the following negedge
   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      trig  = 1'b1;
      addr  = a;
      wdata = d;
      @(negedge clk);
      trig  = 1'b0;
   endtask

   initial begin
      tri_seq  = '{16'd100, 16'd104, 16'd108, 16'd110, 16'd106, 16'd102, 16'd100, 16'd104};
      tri_sync = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      tri_dir  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      saw_seq  = '{16'd100, 16'd104, 16'd108, 16'd110, 16'd100, 16'd104, 16'd108, 16'd110};
      saw_sync = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      big_seq  = '{16'hFFF0, 16'hFFFF, 16'hFFF0, 16'hFFFF};
      big_sync = '{1'b0, 1'b1, 1'b1, 1'b1};

      rst   = 1'b1;
      trig  = 1'b0;
      addr  = 16'd0;
      wdata = 16'd0;
      #12;
      check("rst_dac0", dac0, 16'd0);
      check("rst_dac1", dac1, 16'h8000);
      check("rst_sync", sync, 1'b0);
      check("rst_dir", dir, 1'b0);
      check("rst_rdata", rdata, 16'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_after_rst_dac0", dac0, 16'd0);
      check("idle_after_rst_dir", dir, 1'b0);

      addr = 16'h0102; @(negedge clk); check("rd_max_default", rdata, 16'hFFFF);
      addr = 16'h0105; @(negedge clk); check("rd_offset_default", rdata, 16'h8000);
      addr = 16'h0103; @(negedge clk); check("rd_step_default", rdata, 16'd1);
      addr = 16'h0106; @(negedge clk); check("rd_unmapped_hi", rdata, 16'd0);
      addr = 16'h0050; @(negedge clk); check("rd_unmapped_lo", rdata, 16'd0);

      // triangle 100..110 step 4
      wr(16'h0101, 16'd100);
      wr(16'h0102, 16'd110);
      wr(16'h0103, 16'd4);
      wr(16'h0104, 16'd0);
      wr(16'h0100, 16'd1);
      for (int i = 0; i < 8; i++) begin
         if (i > 0) @(negedge clk);
         check($sformatf("tri_dac0_%0d", i), dac0, tri_seq[i]);
         check($sformatf("tri_sync_%0d", i), sync, tri_sync[i]);
         check($sformatf("tri_dir_%0d", i), dir, tri_dir[i]);
      end
      @(negedge clk);
      check("tri_at_108", dac0, 16'd108);
      wr(16'h0100, 16'd0);
      check("en_clear_dac0", dac0, 16'd100);
      check("en_clear_dir", dir, 1'b0);
      check("en_clear_sync", sync, 1'b0);

      // sawtooth
      wr(16'h0100, 16'd3);
      for (int i = 0; i < 8; i++) begin
         if (i > 0) @(negedge clk);
         check($sformatf("saw_dac0_%0d", i), dac0, saw_seq[i]);
         check($sformatf("saw_sync_%0d", i), sync, saw_sync[i]);
         check($sformatf("saw_dir_%0d", i), dir, 1'b1);
      end
      repeat (3) @(negedge clk);
      check("saw_pre_restart", dac0, 16'd108);
      wr(16'h0100, 16'd7);
      check("restart_dac0", dac0, 16'd100);
      check("restart_dir", dir, 1'b1);
      @(negedge clk);
      check("restart_next", dac0, 16'd104);
      check("rd_ctrl_restart_reads0", rdata, 16'd3);
      wr(16'h0100, 16'd4);
      check("restart_en0_dac0", dac0, 16'd100);
      check("restart_en0_dir", dir, 1'b0);

      wr(16'h0105, 16'h1234);
      check("dac1_offset", dac1, 16'h1234);

      // prescaler DIV=2
      wr(16'h0101, 16'd0);
      wr(16'h0102, 16'd10);
      wr(16'h0103, 16'd1);
      wr(16'h0104, 16'd2);
      wr(16'h0100, 16'd1);
      for (int i = 0; i < 10; i++) begin
         if (i > 0) @(negedge clk);
         check($sformatf("div2_dac0_%0d", i), dac0, 16'(i / 3));
      end

      // top-of-range sweep without overflow
      wr(16'h0100, 16'd0);
      wr(16'h0101, 16'hFFF0);
      wr(16'h0102, 16'hFFFF);
      wr(16'h0103, 16'h0010);
      wr(16'h0104, 16'd0);
      wr(16'h0100, 16'd1);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         check($sformatf("big_dac0_%0d", i), dac0, big_seq[i]);
         check($sformatf("big_sync_%0d", i), sync, big_sync[i]);
      end

      // STEP=0 holds
      wr(16'h0100, 16'd0);
      wr(16'h0103, 16'd0);
      wr(16'h0100, 16'd1);
      check("step0_start", dac0, 16'hFFF0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("step0_dac0_%0d", i), dac0, 16'hFFF0);
         check($sformatf("step0_sync_%0d", i), sync, 1'b0);
         check($sformatf("step0_dir_%0d", i), dir, 1'b1);
      end

      // MIN == MAX keeps the generator idle
      wr(16'h0102, 16'd50);
      wr(16'h0101, 16'd50);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check($sformatf("minmax_dac0_%0d", i), dac0, 16'd50);
         check($sformatf("minmax_dir_%0d", i), dir, 1'b0);
      end

      // asynchronous reset in the middle of a sweep
      wr(16'h0101, 16'd100);
      wr(16'h0102, 16'd110);
      wr(16'h0103, 16'd4);
      check("pre_rst_dac0", dac0, 16'd100);
      repeat (2) @(negedge clk);
      check("pre_rst_dac0_b", dac0, 16'd108);
      #2 rst = 1'b1;
      #1;
      check("async_rst_dac0", dac0, 16'd0);
      check("async_rst_dac1", dac1, 16'h8000);
      check("async_rst_sync", sync, 1'b0);
      check("async_rst_dir", dir, 1'b0);
      check("async_rst_rdata", rdata, 16'd0);
      @(negedge clk);
      rst  = 1'b0;
      addr = 16'h0102;
      @(negedge clk);
      check("post_rst_rd_max", rdata, 16'hFFFF);
      check("post_rst_dac0", dac0, 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
